// File: rtl/alu_ctrl_pkg.sv
// Shared encodings for the EX-stage ALU control: ALU selects, funct codes,
// alu_op classes, multiply/divide kinds and the MD sequencer state type.
package alu_ctrl_pkg;

    localparam logic [3:0] SEL_SUB  = 4'd1;
    localparam logic [3:0] SEL_OR   = 4'd2;
    localparam logic [3:0] SEL_ADD  = 4'd3;
    localparam logic [3:0] SEL_LUI  = 4'd4;
    localparam logic [3:0] SEL_SLL  = 4'd5;
    localparam logic [3:0] SEL_SRL  = 4'd6;
    localparam logic [3:0] SEL_AND  = 4'd7;
    localparam logic [3:0] SEL_NOR  = 4'd8;
    localparam logic [3:0] SEL_NOP  = 4'd9;
    localparam logic [3:0] SEL_SLT  = 4'd10;
    localparam logic [3:0] SEL_MFHI = 4'd11;
    localparam logic [3:0] SEL_MFLO = 4'd12;

    localparam logic [5:0] FUNCT_SLL   = 6'b000000;
    localparam logic [5:0] FUNCT_SRL   = 6'b000010;
    localparam logic [5:0] FUNCT_MFHI  = 6'b010000;
    localparam logic [5:0] FUNCT_MFLO  = 6'b010010;
    localparam logic [5:0] FUNCT_MULT  = 6'b011000;
    localparam logic [5:0] FUNCT_MULTU = 6'b011001;
    localparam logic [5:0] FUNCT_DIV   = 6'b011010;
    localparam logic [5:0] FUNCT_DIVU  = 6'b011011;
    localparam logic [5:0] FUNCT_ADD   = 6'b100000;
    localparam logic [5:0] FUNCT_SUB   = 6'b100010;
    localparam logic [5:0] FUNCT_AND   = 6'b100100;
    localparam logic [5:0] FUNCT_OR    = 6'b100101;
    localparam logic [5:0] FUNCT_NOR   = 6'b100111;
    localparam logic [5:0] FUNCT_SLT   = 6'b101010;

    localparam logic [2:0] OP_LUI   = 3'b001;
    localparam logic [2:0] OP_ORI   = 3'b010;
    localparam logic [2:0] OP_ANDI  = 3'b011;
    localparam logic [2:0] OP_ADDI  = 3'b100;
    localparam logic [2:0] OP_SLTI  = 3'b101;
    localparam logic [2:0] OP_RTYPE = 3'b111;

    localparam logic [1:0] MD_MULT  = 2'b00;
    localparam logic [1:0] MD_MULTU = 2'b01;
    localparam logic [1:0] MD_DIV   = 2'b10;
    localparam logic [1:0] MD_DIVU  = 2'b11;

    typedef logic [0:0] md_state_t;
    localparam md_state_t ST_IDLE = 1'b0;
    localparam md_state_t ST_RUN  = 1'b1;

endpackage

// File: rtl/md_sequencer.sv
// Fixed-latency sequencer for the multiply/divide unit: start gating, kind
// latch, latency down-counter and the HI/LO write strobe.
module md_sequencer
    import alu_ctrl_pkg::*;
#(
    parameter int MUL_LAT = 4,
    parameter int DIV_LAT = 32
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       div_sel,
    input  logic [1:0] md_kind,
    output logic       md_start,
    output logic [1:0] md_op,
    output logic       hilo_we,
    output md_state_t  state
);

    localparam int MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
    localparam int CNT_W   = (MAX_LAT > 1) ? $clog2(MAX_LAT) : 1;
    localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_LAT - 1);
    localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_LAT - 1);

    md_state_t        state_q;
    logic [CNT_W-1:0] cnt;

    assign state    = state_q;
    // Gated by reset directly so a start cannot leak out while reset is held.
    assign md_start = start & (state_q == ST_IDLE) & ~reset;
    assign hilo_we  = (state_q == ST_RUN) && (cnt == '0);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt     <= '0;
            md_op   <= MD_MULT;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        md_op   <= md_kind;
                        cnt     <= div_sel ? DIV_LOAD : MUL_LOAD;
                        state_q <= ST_RUN;
                    end
                end
                default: begin
                    if (cnt != '0) begin
                        cnt <= cnt - 1'b1;
                    end else begin
                        state_q <= ST_IDLE;
                    end
                end
            endcase
        end
    end

endmodule

// File: rtl/alu_control_md.sv
// EX-stage ALU control: combinational ALU select decode, MD start decode and
// the HI/LO interlock stall around the multiply/divide sequencer.
module alu_control_md
    import alu_ctrl_pkg::*;
#(
    parameter int ALU_OP_W  = 3,
    parameter int FUNCT_W   = 6,
    parameter int ALU_SEL_W = 4,
    parameter int MUL_LAT   = 4,
    parameter int DIV_LAT   = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 valid_i,
    input  logic [ALU_OP_W-1:0]  alu_op_i,
    input  logic [FUNCT_W-1:0]   alu_function_i,
    output logic [ALU_SEL_W-1:0] alu_operation_o,
    output logic                 md_start_o,
    output logic [1:0]           md_op_o,
    output logic                 md_busy_o,
    output logic                 hilo_we_o,
    output logic                 stall_o
);

    localparam logic [FUNCT_W-1:0] MD_BASE = FUNCT_W'(FUNCT_MULT);

    logic      is_rtype;
    logic      is_md;
    logic      is_hilo_rd;
    md_state_t md_state;

    assign is_rtype   = (alu_op_i == ALU_OP_W'(OP_RTYPE));
    // All four MD functs share the 0110xx prefix; the low two bits pick the kind.
    assign is_md      = is_rtype && (alu_function_i[FUNCT_W-1:2] == MD_BASE[FUNCT_W-1:2]);
    assign is_hilo_rd = is_rtype && ((alu_function_i == FUNCT_W'(FUNCT_MFHI)) ||
                                     (alu_function_i == FUNCT_W'(FUNCT_MFLO)));

    always_comb begin
        alu_operation_o = ALU_SEL_W'(SEL_NOP);
        if (is_rtype) begin
            case (alu_function_i)
                FUNCT_W'(FUNCT_SUB):  alu_operation_o = ALU_SEL_W'(SEL_SUB);
                FUNCT_W'(FUNCT_OR):   alu_operation_o = ALU_SEL_W'(SEL_OR);
                FUNCT_W'(FUNCT_ADD):  alu_operation_o = ALU_SEL_W'(SEL_ADD);
                FUNCT_W'(FUNCT_SLL):  alu_operation_o = ALU_SEL_W'(SEL_SLL);
                FUNCT_W'(FUNCT_SRL):  alu_operation_o = ALU_SEL_W'(SEL_SRL);
                FUNCT_W'(FUNCT_AND):  alu_operation_o = ALU_SEL_W'(SEL_AND);
                FUNCT_W'(FUNCT_NOR):  alu_operation_o = ALU_SEL_W'(SEL_NOR);
                FUNCT_W'(FUNCT_SLT):  alu_operation_o = ALU_SEL_W'(SEL_SLT);
                FUNCT_W'(FUNCT_MFHI): alu_operation_o = ALU_SEL_W'(SEL_MFHI);
                FUNCT_W'(FUNCT_MFLO): alu_operation_o = ALU_SEL_W'(SEL_MFLO);
                default:              alu_operation_o = ALU_SEL_W'(SEL_NOP);
            endcase
        end else begin
            case (alu_op_i)
                ALU_OP_W'(OP_ADDI): alu_operation_o = ALU_SEL_W'(SEL_ADD);
                ALU_OP_W'(OP_LUI):  alu_operation_o = ALU_SEL_W'(SEL_LUI);
                ALU_OP_W'(OP_ORI):  alu_operation_o = ALU_SEL_W'(SEL_OR);
                ALU_OP_W'(OP_ANDI): alu_operation_o = ALU_SEL_W'(SEL_AND);
                ALU_OP_W'(OP_SLTI): alu_operation_o = ALU_SEL_W'(SEL_SLT);
                default:            alu_operation_o = ALU_SEL_W'(SEL_NOP);
            endcase
        end
    end

    md_sequencer #(
        .MUL_LAT (MUL_LAT),
        .DIV_LAT (DIV_LAT)
    ) u_md_sequencer (
        .clk      (clk),
        .reset    (reset),
        .start    (valid_i & is_md),
        .div_sel  (alu_function_i[1]),
        .md_kind  (alu_function_i[1:0]),
        .md_start (md_start_o),
        .md_op    (md_op_o),
        .hilo_we  (hilo_we_o),
        .state    (md_state)
    );

    assign md_busy_o = (md_state == ST_RUN);
    // Only HI/LO readers and further MD ops wait; plain ALU ops flow past.
    assign stall_o   = md_busy_o & valid_i & (is_md | is_hilo_rd);

endmodule

// File: doc/alu_control_md.md
# alu_control_md

Parametrised ALU control for the EX stage. It decodes `{alu_op_i, alu_function_i}` into the 4-bit ALU operation select and adds SLT/SLTI, MFHI/MFLO decode. It also sequences the multi-cycle multiply/divide unit (MULT, MULTU, DIV, DIVU) with a fixed-latency FSM. It drives the HI/LO write strobe and an interlock stall to the hazard unit so that later HI/LO readers and MD instructions wait.

## Interface
Parameters:
- `ALU_OP_W`, 3: width of alu_op from main control.
- `FUNCT_W`, 6: width of the instruction function field.
- `ALU_SEL_W`, 4: width of the ALU operation select.
- `MUL_LAT`, 4: cycles from MULT/MULTU start to HI/LO write. Legal range ≥1.
- `DIV_LAT`, 32: cycles from DIV/DIVU start to HI/LO write. Legal range ≥1.

Ports:
- `clk`  in  1  single clock, rising edge.
- `reset`  in  1  asynchronous, active-high.
- `valid_i`  in  1  EX holds a real instruction (0 = bubble).
- `alu_op_i`  in  ALU_OP_W  operation class from main control.
- `alu_function_i`  in  FUNCT_W  instruction funct field.
- `alu_operation_o`  out  ALU_SEL_W  ALU select (combinational).
- `md_start_o`  out  1  start pulse to the MD datapath; it captures rs/rt this cycle.
- `md_op_o`  out  2  latched MD kind: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
- `md_busy_o`  out  1  MD operation in flight.
- `hilo_we_o`  out  1  one-cycle HI/LO write strobe.
- `stall_o`  out  1  freeze IF/ID/EX (combinational).

## Operation
- ALU select decode is combinational and independent of `valid_i`:
  - R-type (alu_op 111):
    - SUB 100010→1
    - OR 100101→2
    - ADD 100000→3
    - SLL 000000→5
    - SRL 000010→6
    - AND 100100→7
    - NOR 100111→8
    - SLT 101010→10
    - MFHI 010000→11
    - MFLO 010010→12
  - I-type, funct ignored:
    - ADDI 100→3
    - LUI 001→4
    - ORI 010→2
    - ANDI 011→7
    - SLTI 101→10
  - Everything else, including MD functs 011000–011011, →9 (pass/NOP).
- Decode terms:
  - `is_md`: alu_op 111 with funct 0110xx.
  - `is_hilo_rd`: MFHI or MFLO.
- FSM states are IDLE and RUN. It is driven by a down-counter `cnt` of width clog2(max(MUL_LAT,DIV_LAT)).
- IDLE:
  - If `valid_i & is_md`, then `md_start_o`=1 (combinational) and `md_op_o` latches funct[1:0].
  - `cnt` loads LAT−1, where LAT is MUL_LAT for funct[1]=0 and DIV_LAT otherwise.
  - Next state is RUN.
- RUN:
  - `md_busy_o`=1.
  - If `cnt`≠0, `cnt` decrements.
  - If `cnt`==0, `hilo_we_o`=1 this cycle and the next state is IDLE.
- `stall_o` = `md_busy_o & valid_i & (is_md | is_hilo_rd)`. Independent ALU instructions are never stalled.
- `md_start_o` is never asserted in RUN. A stalled MD instruction starts on the first IDLE cycle it is presented.
- Reset, including mid-operation:
  - state IDLE, `cnt` 0, `md_op_o` 00.
  - `md_busy_o`, `hilo_we_o`, `md_start_o` are 0 while reset is high.
  - `stall_o` is 0 while reset is high.
  - No late `hilo_we_o` pulse follows reset.
  - `alu_operation_o` still follows its inputs.

## Timing
- Start accepted in cycle T: `md_busy_o` is 1 in T+1..T+LAT, and `hilo_we_o` is 1 only in T+LAT.
- MFHI/MFLO presented in T+1..T+LAT stalls. It proceeds in T+LAT+1 and sees the written HI/LO.
- Second MD presented while busy: it stalls, then starts in T+LAT+1, so back-to-back throughput is LAT+1 cycles.
- LAT=1: RUN lasts one cycle with `hilo_we_o` in T+1.
- `valid_i`=0 with MD funct: no start and no state change.
- `md_op_o` holds its value from start until the next start.

## Structure
- Package `alu_ctrl_pkg` holds:
  - ALU select encodings 1–12.
  - funct constants.
  - alu_op class codes.
  - md_op encodings.
  - the FSM state typedef.
- Sub-module `md_sequencer` holds the FSM, counter, `md_op` latch, busy, and hilo_we logic. Its inputs are `start`, `div_sel`, `md_kind`.
- Top-level `alu_control_md` holds the combinational decode and the stall logic.

## Test plan
- Sweep all R functs and I classes with `valid_i`=1 → `alu_operation_o` matches the map above. An unknown funct under alu_op 111 → 9.
- MULT (111_011000) at T, MUL_LAT=4 → `md_start_o`=1 at T; `md_busy_o`=1 at T+1..T+4; `hilo_we_o` only at T+4; `md_op_o`=00.
- DIVU at T with DIV_LAT=32 and MFLO presented at T+1 → `stall_o`=1 at T+1..T+32, 0 at T+33. ADD presented mid-op → `stall_o`=0.
- DIV then MULTU presented at T+1 → MULTU stalls, `md_start_o` at T+33, `md_op_o`=01, `hilo_we_o` at T+37.
- `reset` asserted asynchronously at T+2 of a MULT → outputs clear immediately. No `hilo_we_o` ever appears, and the FSM is IDLE after release.
- MD funct with `valid_i`=0 → no `md_start_o`, `md_busy_o` stays 0.
